// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA colour output stage.
// Mode encoding, sync bundle and the default palette generator.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_PALETTE = 2'd0,
    MODE_DIRECT  = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_BLANK   = 2'd3
  } vga_mode_e;

  localparam int MAX_OUT_BITS = 16;

  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } sync_t;

  // Entry i is {R=i[2],G=i[1],B=i[0]}, each bit replicated out_bits times.
  function automatic logic [3*MAX_OUT_BITS-1:0] default_pal_entry(
    input logic [31:0] idx,
    input int          out_bits
  );
    logic [MAX_OUT_BITS-1:0]   r;
    logic [MAX_OUT_BITS-1:0]   g;
    logic [MAX_OUT_BITS-1:0]   b;
    logic [3*MAX_OUT_BITS-1:0] e;
    r = '0;
    g = '0;
    b = '0;
    for (int k = 0; k < MAX_OUT_BITS; k++) begin
      if (k < out_bits) begin
        r = {r[MAX_OUT_BITS-2:0], idx[2]};
        g = {g[MAX_OUT_BITS-2:0], idx[1]};
        b = {b[MAX_OUT_BITS-2:0], idx[0]};
      end
    end
    e = ({32'b0, r} << (2 * out_bits))
      | ({32'b0, g} << out_bits)
      | {32'b0, b};
    return e;
  endfunction

endpackage

// File: rtl/vga_palette.sv
// Writable colour palette: one write port, registered read.
// Reset restores every entry to its default colour.
module vga_palette
  import vga_pkg::*;
#(
  parameter int OUT_BITS = 4,
  parameter int IDX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_BITS-1:0]   waddr,
  input  logic [3*OUT_BITS-1:0] wdata,
  input  logic [IDX_BITS-1:0]   raddr,
  output logic [3*OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam int CW    = 3 * OUT_BITS;

  logic [CW-1:0] mem [DEPTH];

  // Read samples the pre-write contents, so same-address reads see old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= CW'(default_pal_entry(i, OUT_BITS));
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vga_color_stage.sv
// VGA output stage: palette/direct/bars/blank colour, delayed syncs,
// frame-synchronous mode switching and frame start pulse.
module vga_color_stage
  import vga_pkg::*;
#(
  parameter int OUT_BITS    = 4,
  parameter int IDX_BITS    = 3,
  parameter int PIPE_STAGES = 2,
  parameter bit HS_ACT_LOW  = 1'b1,
  parameter bit VS_ACT_LOW  = 1'b1,
  parameter int BAR_WIDTH   = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  video_on,
  input  logic [IDX_BITS-1:0]   pix_idx,
  input  logic [1:0]            mode_req,
  input  logic                  pal_we,
  input  logic [IDX_BITS-1:0]   pal_addr,
  input  logic [3*OUT_BITS-1:0] pal_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  HS_probe,
  output logic                  VS_probe,
  output logic [OUT_BITS-1:0]   VGA_R,
  output logic [OUT_BITS-1:0]   VGA_G,
  output logic [OUT_BITS-1:0]   VGA_B,
  output logic [1:0]            mode_active,
  output logic                  frame_start
);

  localparam int CW = 3 * OUT_BITS;
  localparam int SW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(BAR_WIDTH - 1);

  logic hs_on;
  logic vs_on;
  logic hs_prev;
  logic vs_prev;
  logic hs_edge;
  logic vs_edge;

  vga_mode_e mode_q;

  logic [SW-1:0]       sub_cnt;
  logic [IDX_BITS-1:0] bar_idx;
  logic [IDX_BITS-1:0] rd_addr;

  sync_t               s1;
  vga_mode_e           s1_mode;
  logic [IDX_BITS-1:0] s1_idx;
  logic [CW-1:0]       pal_q;
  logic [CW-1:0]       c1;

  logic          hs_o;
  logic          vs_o;
  logic [CW-1:0] col_o;
  logic          vs_o_on;
  logic          vs_o_prev;

  assign hs_on   = hsync_in ^ HS_ACT_LOW;
  assign vs_on   = vsync_in ^ VS_ACT_LOW;
  assign hs_edge = hs_on & ~hs_prev;
  assign vs_edge = vs_on & ~vs_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      mode_q  <= MODE_PALETTE;
    end else begin
      hs_prev <= hs_on;
      vs_prev <= vs_on;
      if (vs_edge) begin
        mode_q <= vga_mode_e'(mode_req);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || hs_edge) begin
      sub_cnt <= '0;
      bar_idx <= '0;
    end else if (video_on) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  assign rd_addr = (mode_q == MODE_BARS) ? bar_idx : pix_idx;

  vga_palette #(
    .OUT_BITS (OUT_BITS),
    .IDX_BITS (IDX_BITS)
  ) u_palette (
    .clk   (clk),
    .reset (reset),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_data),
    .raddr (rd_addr),
    .rdata (pal_q)
  );

  // Side-band registers that travel alongside the palette read.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '{hs: HS_ACT_LOW, vs: VS_ACT_LOW, von: 1'b0};
      s1_mode <= MODE_PALETTE;
      s1_idx  <= '0;
    end else begin
      s1      <= '{hs: hsync_in, vs: vsync_in, von: video_on};
      s1_mode <= mode_q;
      s1_idx  <= pix_idx;
    end
  end

  always_comb begin
    c1 = '0;
    if (s1.von) begin
      unique case (s1_mode)
        MODE_PALETTE: c1 = pal_q;
        MODE_DIRECT:  c1 = {{OUT_BITS{s1_idx[2]}},
                            {OUT_BITS{s1_idx[1]}},
                            {OUT_BITS{s1_idx[0]}}};
        MODE_BARS:    c1 = pal_q;
        MODE_BLANK:   c1 = '0;
      endcase
    end
  end

  if (PIPE_STAGES == 1) begin : g_direct
    assign hs_o  = s1.hs;
    assign vs_o  = s1.vs;
    assign col_o = c1;
  end else begin : g_pipe
    localparam int N = PIPE_STAGES - 1;

    logic [N-1:0]  hs_d;
    logic [N-1:0]  vs_d;
    logic [CW-1:0] col_d [N];

    always_ff @(posedge clk) begin
      if (reset) begin
        hs_d <= {N{HS_ACT_LOW}};
        vs_d <= {N{VS_ACT_LOW}};
        for (int k = 0; k < N; k++) begin
          col_d[k] <= '0;
        end
      end else begin
        hs_d[0]  <= s1.hs;
        vs_d[0]  <= s1.vs;
        col_d[0] <= c1;
        for (int k = 1; k < N; k++) begin
          hs_d[k]  <= hs_d[k-1];
          vs_d[k]  <= vs_d[k-1];
          col_d[k] <= col_d[k-1];
        end
      end
    end

    assign hs_o  = hs_d[N-1];
    assign vs_o  = vs_d[N-1];
    assign col_o = col_d[N-1];
  end

  assign vs_o_on = vs_o ^ VS_ACT_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_o_prev <= 1'b0;
    end else begin
      vs_o_prev <= vs_o_on;
    end
  end

  assign frame_start = vs_o_on & ~vs_o_prev & ~reset;

  assign hsync       = hs_o;
  assign vsync       = vs_o;
  assign HS_probe    = hs_o;
  assign VS_probe    = vs_o;
  assign VGA_R       = col_o[CW-1 -: OUT_BITS];
  assign VGA_G       = col_o[2*OUT_BITS-1 -: OUT_BITS];
  assign VGA_B       = col_o[OUT_BITS-1:0];
  assign mode_active = mode_q;

endmodule

// File: tb/tb_vga_color_stage.sv
// Scoreboard bench for vga_color_stage: random pixels and palette writes
// over a short 800-clock-line frame, checked against a reference model.
module tb_vga_color_stage;

  localparam int OB = 4;
  localparam int IB = 3;
  localparam int P  = 2;
  localparam int BW = 80;

  localparam int HT = 800;
  localparam int HA = 640;
  localparam int HS0 = 656;
  localparam int HS1 = 752;
  localparam int VT = 10;
  localparam int VA = 6;
  localparam int VS0 = 7;
  localparam int VS1 = 9;
  localparam int FRAMES = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_in;
  logic        vsync_in;
  logic        video_on;
  logic [2:0]  pix_idx;
  logic [1:0]  mode_req;
  logic        pal_we;
  logic [2:0]  pal_addr;
  logic [11:0] pal_data;
  logic        hsync;
  logic        vsync;
  logic        HS_probe;
  logic        VS_probe;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic [1:0]  mode_active;
  logic        frame_start;

  always #5 clk = ~clk;

  vga_color_stage #(
    .OUT_BITS    (OB),
    .IDX_BITS    (IB),
    .PIPE_STAGES (P),
    .HS_ACT_LOW  (1'b1),
    .VS_ACT_LOW  (1'b1),
    .BAR_WIDTH   (BW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .video_on    (video_on),
    .pix_idx     (pix_idx),
    .mode_req    (mode_req),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .HS_probe    (HS_probe),
    .VS_probe    (VS_probe),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .mode_active (mode_active),
    .frame_start (frame_start)
  );

  typedef struct {
    int          due;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    int         due;
    logic [1:0] mode;
  } mode_t;

  pix_t  pq[$];
  mode_t mq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fs_seen = 0;

  logic [11:0] pal_m [8];
  int          mode_m;
  int          px;
  bit          hs_prev_m;
  bit          vs_prev_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] rep3(input logic [2:0] i);
    return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
  endfunction

  task automatic model_reset(input int k);
    pix_t  e;
    mode_t m;
    for (int i = 0; i < 8; i++) pal_m[i] = rep3(3'(i));
    mode_m    = 0;
    px        = 0;
    hs_prev_m = 1'b0;
    vs_prev_m = 1'b0;
    while (pq.size() > 0 && pq[$].due > k) void'(pq.pop_back());
    for (int d = 1; d <= P; d++) begin
      e.due = k + d;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = '0;
      pq.push_back(e);
    end
    m.due  = k + 1;
    m.mode = 2'd0;
    mq.push_back(m);
  endtask

  task automatic model_step(input int k, input bit hsa, input bit vsa,
                            input bit von, input logic [2:0] idx,
                            input bit we, input logic [2:0] addr,
                            input logic [11:0] data, input logic [1:0] mreq);
    pix_t  e;
    mode_t m;
    e.due = k + P;
    e.hs  = ~hsa;
    e.vs  = ~vsa;
    e.rgb = '0;
    if (von) begin
      case (mode_m)
        0:       e.rgb = pal_m[idx];
        1:       e.rgb = rep3(idx);
        2:       e.rgb = pal_m[(px / BW) % 8];
        default: e.rgb = '0;
      endcase
    end
    pq.push_back(e);
    if (we) pal_m[addr] = data;
    if (hsa && !hs_prev_m) px = 0;
    else if (von) px++;
    if (vsa && !vs_prev_m) mode_m = int'(mreq);
    hs_prev_m = hsa;
    vs_prev_m = vsa;
    m.due  = k + 1;
    m.mode = 2'(mode_m);
    mq.push_back(m);
  endtask

  bit prev_vs_exp = 1'b0;

  always @(negedge clk) begin
    pix_t  e;
    mode_t m;
    bit    fs_exp;
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      e = pq.pop_front();
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("HS_probe", 32'(HS_probe), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("VS_probe", 32'(VS_probe), 32'(e.vs));
      chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
      fs_exp = ~e.vs && !prev_vs_exp && !reset;
      chk("frame_start", 32'(frame_start), 32'(fs_exp));
      prev_vs_exp = ~e.vs;
    end
    while (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      chk("mode_active", 32'(mode_active), 32'(m.mode));
    end
    if (frame_start === 1'b1) fs_seen++;
  end

  logic [1:0] mtab [FRAMES];

  initial begin
    bit hsa;
    bit vsa;
    bit von;
    mtab = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
    reset    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    video_on = 1'b0;
    pix_idx  = '0;
    mode_req = 2'd0;
    pal_we   = 1'b0;
    pal_addr = '0;
    pal_data = '0;
    for (int f = 0; f < FRAMES; f++) begin
      for (int v = 0; v < VT; v++) begin
        for (int h = 0; h < HT; h++) begin
          @(posedge clk);
          #1;
          von = (h < HA) && (v < VA);
          hsa = (h >= HS0) && (h < HS1);
          vsa = (v >= VS0) && (v < VS1);
          hsync_in = ~hsa;
          vsync_in = ~vsa;
          video_on = von;
          pix_idx  = 3'($urandom_range(0, 7));
          pal_we   = ($urandom_range(0, 19) == 0);
          pal_addr = 3'($urandom_range(0, 7));
          pal_data = 12'($urandom);
          if (v == 3 && h == 0) mode_req = mtab[f];
          reset = (f == 0 && v == 0 && h < 2) || (f == 2 && v == 2 && h == 300);
          if (f == 0 && v == 0 && h == 10) begin
            pal_we   = 1'b1;
            pal_addr = 3'd5;
            pal_data = 12'h3C7;
            pix_idx  = 3'd5;
          end
          if (f == 0 && v == 0 && h == 11) begin
            pal_we  = 1'b0;
            pix_idx = 3'd5;
          end
          if (f == 2 && v == 2 && h == 299) begin
            pal_we   = 1'b1;
            pal_addr = 3'd5;
          end
          if (f == 2 && v == 2 && h > 300 && h < 306) begin
            pal_we  = 1'b0;
            pix_idx = 3'd5;
          end
          if (reset) model_reset(cyc);
          else model_step(cyc, hsa, vsa, von, pix_idx, pal_we, pal_addr,
                          pal_data, mode_req);
        end
      end
    end
    repeat (P + 3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(pq.size() + mq.size()), 32'd0);
    chk("frame_count", 32'(fs_seen), 32'(FRAMES));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
